// File: rtl/mac_array_ctrl.sv
// Sequencer for the 1-D MAC column chain: streams key vectors (LOAD), then query
// vectors (EXEC) from SRAM, then waits for the last column's fifo writes (DRAIN).
module mac_array_ctrl #(
  parameter int COL      = 8,
  parameter int KEY_LEN  = 10,
  parameter int Q_LEN    = 8,
  parameter int AW       = 6,
  parameter int KEY_BASE = 0,
  parameter int Q_BASE   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_ofifo_full,
  input  logic          i_last_wr,
  output logic          o_mem_cen,
  output logic [AW-1:0] o_mem_addr,
  output logic [1:0]    o_inst,
  output logic          o_busy,
  output logic          o_done
);

  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   KEY_LEN_C  = CW'(KEY_LEN);
  localparam logic [CW-1:0]   Q_LEN_C    = CW'(Q_LEN);
  localparam logic [AW-1:0]   KEY_BASE_A = AW'(KEY_BASE);
  localparam logic [AW-1:0]   Q_BASE_A   = AW'(Q_BASE);
  // A run is only launched for a legal chain configuration.
  localparam logic            CFG_OK     = (COL >= 1) && (KEY_LEN >= 1) &&
                                           (Q_LEN >= 1) && (Q_LEN <= (1 << AW));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_wcnt, w_wcnt_nxt;
  logic [CW-1:0] w_wcnt_inc;
  logic          w_wr_in;
  logic          r_mem_cen, w_mem_cen_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0]    r_inst, w_inst_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  // r_state names the phase of the beat currently on the SRAM port, so the
  // instruction for column 0 is simply that beat's type one cycle later.
  assign w_wr_in    = i_last_wr && ((r_state == S_EXEC) || (r_state == S_DRAIN));
  assign w_wcnt_inc = r_wcnt + {{(CW-1){1'b0}}, w_wr_in};

  // Next-state, issue and output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wcnt_nxt     = r_wcnt;
    w_mem_cen_nxt  = 1'b1;
    w_mem_addr_nxt = r_mem_addr;
    w_done_nxt     = 1'b0;

    if (!r_mem_cen && (r_state == S_LOAD)) begin
      w_inst_nxt = 2'b01;
    end else if (!r_mem_cen && (r_state == S_EXEC)) begin
      w_inst_nxt = 2'b10;
    end else begin
      w_inst_nxt = 2'b00;
    end

    case (r_state)
      S_IDLE: begin
        w_wcnt_nxt = CNT_ZERO;
        // A start seen while the done pulse is still out belongs to the old run.
        if (i_start && !r_done && CFG_OK) begin
          w_state_nxt    = S_LOAD;
          w_mem_cen_nxt  = 1'b0;
          w_mem_addr_nxt = KEY_BASE_A;
          w_cnt_nxt      = CNT_ONE;
        end else begin
          w_cnt_nxt = CNT_ZERO;
        end
      end
      S_LOAD: begin
        w_wcnt_nxt = CNT_ZERO;
        if (r_cnt < KEY_LEN_C) begin
          w_mem_cen_nxt  = 1'b0;
          w_mem_addr_nxt = KEY_BASE_A + r_cnt[AW-1:0];
          w_cnt_nxt      = r_cnt + CNT_ONE;
        end else if (!i_ofifo_full) begin
          w_state_nxt    = S_EXEC;
          w_mem_cen_nxt  = 1'b0;
          w_mem_addr_nxt = Q_BASE_A;
          w_cnt_nxt      = CNT_ONE;
        end else begin
          w_state_nxt    = S_EXEC;
          w_mem_addr_nxt = Q_BASE_A;
          w_cnt_nxt      = CNT_ZERO;
        end
      end
      S_EXEC: begin
        w_wcnt_nxt = w_wcnt_inc;
        if (r_cnt >= Q_LEN_C) begin
          w_state_nxt = S_DRAIN;
        end else if (!i_ofifo_full) begin
          w_mem_cen_nxt  = 1'b0;
          w_mem_addr_nxt = Q_BASE_A + r_cnt[AW-1:0];
          w_cnt_nxt      = r_cnt + CNT_ONE;
        end else begin
          w_mem_addr_nxt = Q_BASE_A + r_cnt[AW-1:0];
        end
      end
      S_DRAIN: begin
        if (w_wcnt_inc >= Q_LEN_C) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_wcnt_nxt  = CNT_ZERO;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_wcnt_nxt = w_wcnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_wcnt_nxt  = CNT_ZERO;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_wcnt     <= CNT_ZERO;
      r_mem_cen  <= 1'b1;
      r_mem_addr <= {AW{1'b0}};
      r_inst     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_mem_cen  <= w_mem_cen_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_inst     <= w_inst_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_mem_cen  = r_mem_cen;
  assign o_mem_addr = r_mem_addr;
  assign o_inst     = r_inst;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: SRAM and an 8-column MAC chain around the sequencer,
// directed and randomized runs checked against a rule-level expected trace.
module tb_mac_array_ctrl;
  localparam int COL = 8, KEY_LEN = 10, Q_LEN = 8, AW = 6, KEY_BASE = 0, Q_BASE = 16;
  localparam int NC = 96;

  logic clk = 1'b0;
  logic reset, i_start, i_ofifo_full, i_last_wr, man_wr, clr_log;
  logic o_mem_cen, o_busy, o_done;
  logic [AW-1:0] o_mem_addr;
  logic [1:0] o_inst;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_array_ctrl #(.COL(COL), .KEY_LEN(KEY_LEN), .Q_LEN(Q_LEN), .AW(AW),
                   .KEY_BASE(KEY_BASE), .Q_BASE(Q_BASE)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_ofifo_full(i_ofifo_full),
    .i_last_wr(i_last_wr), .o_mem_cen(o_mem_cen), .o_mem_addr(o_mem_addr),
    .o_inst(o_inst), .o_busy(o_busy), .o_done(o_done));

  // SRAM with one-cycle read latency and a chain of MAC columns (keys shift down on LOAD).
  logic [7:0]  sram [64];
  logic [7:0]  rdata;
  logic [1:0]  c_inst [COL];
  logic [7:0]  c_d [COL];
  logic [7:0]  c_key [COL];
  logic        c_wr [COL];
  logic [1:0]  c_in_inst [COL];
  logic [7:0]  c_in_d [COL];
  logic [15:0] wlog [COL][16];
  int          nlog [COL];

  always_comb begin
    c_in_inst[0] = o_inst;
    c_in_d[0]    = rdata;
    for (int k = 1; k < COL; k++) begin
      c_in_inst[k] = c_inst[k-1];
      c_in_d[k]    = c_d[k-1];
    end
  end

  always @(posedge clk) begin
    if (!o_mem_cen) rdata <= sram[o_mem_addr];
    for (int k = 0; k < COL; k++) begin
      if (reset) begin
        c_inst[k] <= 2'b00;
        c_wr[k]   <= 1'b0;
      end else begin
        c_inst[k] <= c_in_inst[k];
        c_wr[k]   <= c_in_inst[k][1];
      end
      if (c_in_inst[k][0]) begin
        c_key[k] <= c_in_d[k];
        c_d[k]   <= c_key[k];
      end else begin
        c_d[k] <= c_in_d[k];
      end
      if (clr_log) begin
        nlog[k] <= 0;
      end else if (c_in_inst[k][1] && !reset && nlog[k] < 16) begin
        wlog[k][nlog[k]] <= 16'(c_key[k]) * 16'(c_in_d[k]);
        nlog[k] <= nlog[k] + 1;
      end
    end
  end

  assign i_last_wr = c_wr[COL-1] | man_wr;

  // Stimulus patterns, recorded trace and expected trace, indexed by cycle.
  logic p_start [NC], p_full [NC], p_mwr [NC];
  logic tr_cen [NC], tr_busy [NC], tr_done [NC];
  logic [AW-1:0] tr_addr [NC];
  logic [1:0] tr_inst [NC];
  logic e_cen [NC], e_busy [NC], e_done [NC], e_addr_v [NC];
  logic [AW-1:0] e_addr [NC];
  logic [1:0] e_inst [NC];
  int m_dn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pats();
    for (int c = 0; c < NC; c++) begin
      p_start[c] = 1'b0;
      p_full[c]  = 1'b0;
      p_mwr[c]   = 1'b0;
    end
  endtask

  task automatic fill_sram();
    for (int a = 0; a < 64; a++) sram[a] = 8'($urandom);
  endtask

  task automatic run(input int n);
    clr_log = 1'b1;
    @(posedge clk); #1;
    clr_log = 1'b0;
    for (int k = 0; k < n; k++) begin
      tr_cen[k]  = o_mem_cen;
      tr_addr[k] = o_mem_addr;
      tr_inst[k] = o_inst;
      tr_busy[k] = o_busy;
      tr_done[k] = o_done;
      i_start      = p_start[k];
      i_ofifo_full = p_full[k];
      man_wr       = p_mwr[k];
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_ofifo_full = 1'b0;
    man_wr = 1'b0;
  endtask

  // Expected trace from the run rules: KEY_LEN key beats right after start, then
  // Q_LEN query beats skipping cycles with the FIFO full, inst = beat type a cycle
  // later, done once the last query has crossed all COL columns (s < 0: no run).
  task automatic model(input int s, input int n);
    int t, q, last;
    for (int c = 0; c < n; c++) begin
      e_cen[c] = 1'b1; e_busy[c] = 1'b0; e_done[c] = 1'b0;
      e_addr_v[c] = 1'b0; e_addr[c] = '0; e_inst[c] = 2'b00;
    end
    m_dn = -1;
    if (s >= 0) begin
      t = s + 1;
      for (int j = 0; j < KEY_LEN; j++) begin
        e_cen[t] = 1'b0; e_addr[t] = AW'(KEY_BASE + j); e_addr_v[t] = 1'b1;
        e_inst[t+1] = 2'b01;
        t++;
      end
      q = 0;
      while (q < Q_LEN && t < NC - 2) begin
        e_addr[t] = AW'(Q_BASE + q); e_addr_v[t] = 1'b1;
        if (!p_full[t-1]) begin
          e_cen[t] = 1'b0; e_inst[t+1] = 2'b10; q++;
        end
        t++;
      end
      last = t - 1;
      m_dn = last + COL + 2;
      for (int c = s + 1; c < m_dn && c < n; c++) e_busy[c] = 1'b1;
      if (m_dn < n) e_done[m_dn] = 1'b1;
    end
  endtask

  task automatic cmp_trace(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s.cen@%0d", tag, c), 32'(tr_cen[c]), 32'(e_cen[c]));
      chk($sformatf("%s.inst@%0d", tag, c), 32'(tr_inst[c]), 32'(e_inst[c]));
      chk($sformatf("%s.busy@%0d", tag, c), 32'(tr_busy[c]), 32'(e_busy[c]));
      chk($sformatf("%s.done@%0d", tag, c), 32'(tr_done[c]), 32'(e_done[c]));
      if (e_addr_v[c]) chk($sformatf("%s.addr@%0d", tag, c), 32'(tr_addr[c]), 32'(e_addr[c]));
    end
  endtask

  // Column k must hold key vector KEY_LEN-1-k and write key*query for every query.
  task automatic chk_chain(input string tag);
    logic [15:0] kv, qv;
    for (int k = 0; k < COL; k++) begin
      kv = 16'(sram[KEY_BASE + KEY_LEN - 1 - k]);
      chk($sformatf("%s.key%0d", tag, k), 32'(c_key[k]), 32'(kv));
      chk($sformatf("%s.nwr%0d", tag, k), 32'(nlog[k]), 32'(Q_LEN));
      for (int j = 0; j < Q_LEN && j < nlog[k]; j++) begin
        qv = 16'(sram[Q_BASE + j]);
        chk($sformatf("%s.dot%0d_%0d", tag, k, j), 32'(wlog[k][j]), 32'(kv * qv));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cen"}, 32'(o_mem_cen), 32'd1);
    chk({tag, ".addr"}, 32'(o_mem_addr), 32'd0);
    chk({tag, ".inst"}, 32'(o_inst), 32'd0);
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".done"}, 32'(o_done), 32'd0);
  endtask

  int ndone, n10, nbub, s0;

  initial begin
    reset = 1'b1; i_start = 1'b0; i_ofifo_full = 1'b0; man_wr = 1'b0; clr_log = 1'b0;
    fill_sram();
    #1;
    chk_reset_vals("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // 1: idle after reset, stray last_wr pulses ignored
    clear_pats();
    p_mwr[5] = 1'b1; p_mwr[12] = 1'b1;
    model(-1, 20); run(20); cmp_trace("idle", 20);

    // 2: nominal run, last_wr pulses during IDLE/LOAD must not count
    clear_pats();
    p_start[0] = 1'b1; p_mwr[0] = 1'b1; p_mwr[3] = 1'b1; p_mwr[7] = 1'b1;
    model(0, 40); run(40); cmp_trace("nom", 40);
    chk("nom.addr1", 32'(tr_addr[1]), 32'd0);
    chk("nom.addr10", 32'(tr_addr[10]), 32'd9);
    chk("nom.addr11", 32'(tr_addr[11]), 32'd16);
    chk("nom.addr18", 32'(tr_addr[18]), 32'd23);
    chk("nom.inst11", 32'(tr_inst[11]), 32'd1);
    chk("nom.inst12", 32'(tr_inst[12]), 32'd2);
    chk("nom.inst20", 32'(tr_inst[20]), 32'd0);
    chk("nom.done28", 32'(tr_done[28]), 32'd1);
    chk("nom.busy28", 32'(tr_busy[28]), 32'd0);
    chk_chain("nom");

    // 3: FIFO full for three cycles after the 4th query issue
    clear_pats();
    p_start[0] = 1'b1; p_full[14] = 1'b1; p_full[15] = 1'b1; p_full[16] = 1'b1;
    model(0, 45); run(45); cmp_trace("stall", 45);
    for (int c = 15; c <= 17; c++) begin
      chk($sformatf("stall.hold@%0d", c), 32'(tr_addr[c]), 32'd20);
      chk($sformatf("stall.cen@%0d", c), 32'(tr_cen[c]), 32'd1);
    end
    n10 = 0; nbub = 0;
    for (int c = 0; c < 45; c++) if (tr_inst[c] == 2'b10) n10++;
    for (int c = 12; c <= 22; c++) if (tr_inst[c] == 2'b00) nbub++;
    chk("stall.n_exec", 32'(n10), 32'd8);
    chk("stall.n_bubble", 32'(nbub), 32'd3);
    chk_chain("stall");

    // 4: start during EXEC, DRAIN and on the done cycle is ignored; then a fresh run
    clear_pats();
    model(0, 40);
    p_start[0] = 1'b1; p_start[13] = 1'b1; p_start[m_dn-1] = 1'b1; p_start[m_dn] = 1'b1;
    run(40); cmp_trace("busy_start", 40);
    ndone = 0;
    for (int c = 0; c < 40; c++) if (tr_done[c]) ndone++;
    chk("busy_start.ndone", 32'(ndone), 32'd1);
    clear_pats();
    p_start[0] = 1'b1;
    model(0, 40); run(40); cmp_trace("fresh", 40); chk_chain("fresh");

    // 5: reset right after the 3rd query issue, then an exact replay
    clear_pats();
    p_start[0] = 1'b1;
    run(14);
    chk("mid.addr13", 32'(tr_addr[13]), 32'd18);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    clear_pats();
    p_start[0] = 1'b1;
    model(0, 40); run(40); cmp_trace("replay", 40); chk_chain("replay");

    // 6: randomized SRAM contents, start offset and FIFO back-pressure
    for (int r = 0; r < 4; r++) begin
      fill_sram();
      clear_pats();
      s0 = $urandom_range(0, 3);
      p_start[s0] = 1'b1;
      for (int c = 0; c <= s0 + KEY_LEN; c++) p_mwr[c] = ($urandom_range(0, 3) == 0);
      for (int c = s0 + 10; c <= s0 + 50; c++) p_full[c] = ($urandom_range(0, 2) == 0);
      model(s0, 80); run(80);
      cmp_trace($sformatf("rnd%0d", r), 80);
      chk_chain($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
